seg_level_decoder: RTL and testbench

//   Receive-side counterpart of the tank-level 7-segment encoder: takes an 8-bit segment

---
 rtl/seg_level_decoder.sv | 161 ++++++++++++++++
 tb/tb_seg_level_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_level_decoder.sv
// seg_level_decoder
//   Receive-side decoder for the tank-level 7-segment display. It takes an
//   8-bit segment pattern, either from switches or captured from a SEG bus,
//   and recovers the 2-bit level code.
//
//   A pattern is committed only after it has been seen on STABLE_CYCLES
//   consecutive enabled samples. Edges where sample_en is low neither advance
//   nor break a run. A committed pattern that is not in the code table raises
//   code_err. A committed change of a valid level is counted for display.
//
//   Code table (exact 8-bit match, dp bit included):
//     0x77 -> 00 alto, 0x54 -> 01 normal, 0x7C -> 10 baixo, 0x5E -> 11 descalibrado
//
// Configuration macro: SEG_ACTIVE_LOW_EN
//   defined   : seg_in is bitwise inverted before any comparison (common-anode)
//   undefined : seg_in is used as-is (active-high segments)
//
// Ports
//   clk_2        in   1      system clock, rising edge
//   reset        in   1      asynchronous active-high reset
//   seg_in       in   NBITS  segment pattern to decode
//   sample_en    in   1      seg_in is sampled only on edges where this is 1
//   level        out  2      committed level code
//   level_valid  out  1      level holds a committed valid code
//   code_err     out  1      last committed pattern was not in the code table
//   change_pulse out  1      one-cycle pulse when the committed level changes
//   change_cnt   out  CNT_W  number of change pulses, saturating at all-ones
//   fsm_state    out  2      FSM state for LCD debug (0 IDLE, 1 CONFIRM, 2 STABLE, 3 ERR)

module seg_level_decoder #(
   parameter int NBITS         = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [NBITS-1:0] seg_in,
   input  logic             sample_en,
   output logic [1:0]       level,
   output logic             level_valid,
   output logic             code_err,
   output logic             change_pulse,
   output logic [CNT_W-1:0] change_cnt,
   output logic [1:0]       fsm_state
);

   localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      STABLE  = 2'd2,
      ERR     = 2'd3
   } state_t;

   state_t           state_r;
   logic [NBITS-1:0] cand_r;
   logic [RUN_W-1:0] run_cnt_r;

   logic [NBITS-1:0] seg_s;
   logic             match_s;
   logic [RUN_W-1:0] run_next_s;
   logic             commit_s;
   logic [2:0]       dec_s;

   // Table lookup: returns {valid, code}; unknown patterns give valid=0.
   function automatic logic [2:0] decode(input logic [NBITS-1:0] p);
      logic [2:0] r;
      case (p)
         NBITS'(8'h77): r = 3'b1_00;
         NBITS'(8'h54): r = 3'b1_01;
         NBITS'(8'h7C): r = 3'b1_10;
         NBITS'(8'h5E): r = 3'b1_11;
         default:       r = 3'b0_00;
      endcase
      return r;
   endfunction

`ifdef SEG_ACTIVE_LOW_EN
   assign seg_s = ~seg_in;
`else
   assign seg_s = seg_in;
`endif

   assign fsm_state = state_r;

   // Run tracking and commit detection for the current enabled sample.
   always_comb begin
      match_s    = (seg_s == cand_r) && (run_cnt_r != {RUN_W{1'b0}});
      run_next_s = RUN_ONE;
      commit_s   = 1'b0;
      dec_s      = decode(seg_s);
      if (match_s) begin
         if (run_cnt_r == RUN_MAX) begin
            run_next_s = RUN_MAX;
         end else begin
            run_next_s = run_cnt_r + RUN_ONE;
         end
      end else begin
         run_next_s = RUN_ONE;
      end
      // A single-sample window commits every enabled sample; otherwise only
      // the edge that reaches the window commits, not a saturated run.
      if (STABLE_CYCLES == 1) begin
         commit_s = sample_en;
      end else begin
         commit_s = sample_en && (run_next_s == RUN_MAX) && (run_cnt_r != RUN_MAX);
      end
   end

   // FSM, candidate tracking and registered outputs.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         cand_r       <= {NBITS{1'b0}};
         run_cnt_r    <= {RUN_W{1'b0}};
         level        <= 2'b00;
         level_valid  <= 1'b0;
         code_err     <= 1'b0;
         change_pulse <= 1'b0;
         change_cnt   <= {CNT_W{1'b0}};
      end else begin
         change_pulse <= 1'b0;
         if (sample_en) begin
            cand_r    <= seg_s;
            run_cnt_r <= run_next_s;
            if (commit_s) begin
               if (dec_s[2]) begin
                  level       <= dec_s[1:0];
                  level_valid <= 1'b1;
                  code_err    <= 1'b0;
                  state_r     <= STABLE;
                  if (level_valid && (dec_s[1:0] != level)) begin
                     change_pulse <= 1'b1;
                     if (change_cnt != {CNT_W{1'b1}}) begin
                        change_cnt <= change_cnt + CNT_W'(1);
                     end else begin
                        change_cnt <= change_cnt;
                     end
                  end else begin
                     change_cnt <= change_cnt;
                  end
               end else begin
                  code_err    <= 1'b1;
                  level_valid <= 1'b0;
                  state_r     <= ERR;
               end
            end else if (!match_s) begin
               state_r <= CONFIRM;
            end else begin
               state_r <= state_r;
            end
         end else begin
            state_r <= state_r;
         end
      end
   end

endmodule

// File: tb/tb_seg_level_decoder.sv
// Directed self-checking bench for seg_level_decoder (default parameters).
// Patterns are written in active-high form and inverted by enc() when the
// active-low build is selected, so the same expectations hold in both builds.

module tb_seg_level_decoder;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] seg_in = 8'h00;
   logic       sample_en = 1'b0;
   logic [1:0] level;
   logic       level_valid;
   logic       code_err;
   logic       change_pulse;
   logic [7:0] change_cnt;
   logic [1:0] fsm_state;

   int checks = 0;
   int errors = 0;

   seg_level_decoder dut (
      .clk_2       (clk_2),
      .reset       (reset),
      .seg_in      (seg_in),
      .sample_en   (sample_en),
      .level       (level),
      .level_valid (level_valid),
      .code_err    (code_err),
      .change_pulse(change_pulse),
      .change_cnt  (change_cnt),
      .fsm_state   (fsm_state)
   );

   always #5 clk_2 = ~clk_2;

   function automatic logic [7:0] enc(input logic [7:0] p);
`ifdef SEG_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   // One clock edge with the given inputs; returns 1 ns after the edge.
   task automatic step(input logic [7:0] p, input logic en);
      seg_in    = enc(p);
      sample_en = en;
      @(posedge clk_2);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (level !== 2'b00) begin errors++; $display("FAIL reset_level got %b exp 00", level); end
      checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", level_valid); end
      checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", code_err); end
      checks++; if (change_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", change_cnt); end
      checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
      @(negedge clk_2);
      reset = 1'b0;
   endtask

   task automatic test_first_commit();
      for (int i = 0; i < 3; i++) step(8'h54, 1'b1);
      checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL early_commit valid got %b exp 0", level_valid); end
      checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL confirm_state got %0d exp 1", fsm_state); end
      step(8'h54, 1'b1);
      checks++; if (level !== 2'b01) begin errors++; $display("FAIL first_level got %b exp 01", level); end
      checks++; if (level_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", level_valid); end
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL first_pulse got %b exp 0", change_pulse); end
      checks++; if (change_cnt !== 8'h00) begin errors++; $display("FAIL first_cnt got %h exp 00", change_cnt); end
      checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL stable_state got %0d exp 2", fsm_state); end
   endtask

   task automatic test_change();
      for (int i = 0; i < 3; i++) step(8'h77, 1'b1);
      step(8'h54, 1'b1);
      checks++; if (level !== 2'b01) begin errors++; $display("FAIL broken_run level got %b exp 01", level); end
      checks++; if (change_cnt !== 8'h00) begin errors++; $display("FAIL broken_run cnt got %h exp 00", change_cnt); end
      for (int i = 0; i < 3; i++) step(8'h77, 1'b1);
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL pre_change pulse got %b exp 0", change_pulse); end
      step(8'h77, 1'b1);
      checks++; if (level !== 2'b00) begin errors++; $display("FAIL change_level got %b exp 00", level); end
      checks++; if (change_pulse !== 1'b1) begin errors++; $display("FAIL change_pulse got %b exp 1", change_pulse); end
      checks++; if (change_cnt !== 8'h01) begin errors++; $display("FAIL change_cnt got %h exp 01", change_cnt); end
      step(8'h77, 1'b1);
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL pulse_width got %b exp 0", change_pulse); end
      checks++; if (change_cnt !== 8'h01) begin errors++; $display("FAIL saturated_run cnt got %h exp 01", change_cnt); end
   endtask

   task automatic test_sample_enable();
      for (int i = 0; i < 3; i++) begin
         step(8'h7C, 1'b1);
         step(8'h7C, 1'b0);
      end
      checks++; if (level !== 2'b00) begin errors++; $display("FAIL en_early level got %b exp 00", level); end
      step(8'h7C, 1'b1);
      checks++; if (level !== 2'b10) begin errors++; $display("FAIL en_commit level got %b exp 10", level); end
      checks++; if (change_cnt !== 8'h02) begin errors++; $display("FAIL en_commit cnt got %h exp 02", change_cnt); end
   endtask

   task automatic test_invalid_code();
      for (int i = 0; i < 4; i++) step(8'h12, 1'b1);
      checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", code_err); end
      checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL bad_valid got %b exp 0", level_valid); end
      checks++; if (level !== 2'b10) begin errors++; $display("FAIL bad_level got %b exp 10", level); end
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL bad_pulse got %b exp 0", change_pulse); end
      checks++; if (fsm_state !== 2'd3) begin errors++; $display("FAIL err_state got %0d exp 3", fsm_state); end
      step(8'h5E, 1'b1);
      checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL err_exit state got %0d exp 1", fsm_state); end
      for (int i = 0; i < 3; i++) step(8'h5E, 1'b1);
      checks++; if (level !== 2'b11) begin errors++; $display("FAIL recover_level got %b exp 11", level); end
      checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL recover_err got %b exp 0", code_err); end
      checks++; if (level_valid !== 1'b1) begin errors++; $display("FAIL recover_valid got %b exp 1", level_valid); end
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL recover_pulse got %b exp 0", change_pulse); end
      checks++; if (change_cnt !== 8'h02) begin errors++; $display("FAIL recover_cnt got %h exp 02", change_cnt); end
   endtask

   task automatic test_async_reset();
      step(8'h54, 1'b1);
      step(8'h54, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checks++; if (level !== 2'b00) begin errors++; $display("FAIL areset_level got %b exp 00", level); end
      checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", level_valid); end
      checks++; if (change_cnt !== 8'h00) begin errors++; $display("FAIL areset_cnt got %h exp 00", change_cnt); end
      checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL areset_state got %0d exp 0", fsm_state); end
      @(negedge clk_2);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step(8'h54, 1'b1);
      checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL fresh_run early valid got %b exp 0", level_valid); end
      step(8'h54, 1'b1);
      checks++; if (level !== 2'b01) begin errors++; $display("FAIL fresh_run level got %b exp 01", level); end
      checks++; if (level_valid !== 1'b1) begin errors++; $display("FAIL fresh_run valid got %b exp 1", level_valid); end
   endtask

   task automatic test_cnt_saturation();
      logic [7:0] p;
      for (int n = 1; n <= 258; n++) begin
         p = (n % 2 == 1) ? 8'h77 : 8'h54;
         for (int i = 0; i < 4; i++) step(p, 1'b1);
         if (n == 10 || n == 254 || n == 255 || n == 258) begin
            checks++;
            if (change_cnt !== ((n > 255) ? 8'hFF : 8'(n))) begin
               errors++; $display("FAIL sat_cnt after %0d changes got %h", n, change_cnt);
            end
            checks++;
            if (change_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse after %0d changes got %b exp 1", n, change_pulse); end
         end
      end
      checks++; if (level !== 2'b01) begin errors++; $display("FAIL sat_level got %b exp 01", level); end
   endtask

   initial begin
      test_reset();
      test_first_commit();
      test_change();
      test_sample_enable();
      test_invalid_code();
      test_async_reset();
      test_cnt_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
